// File: rtl/pri_encoder_hs.sv
// Purpose: captures request rising edges into sticky pending bits and hands the highest pending index to a valid/ready consumer.
// Latency: 2 cycles from the edge that samples a rise to code_valid; back-to-back codes with no bubble while requests remain.
// Backpressure: code_o is held stable while code_ready is low; new requests accumulate in pending, and a repeat of a pending request sets overrun.
module pri_encoder_hs #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] code_o,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [N-1:0] pending,
    output logic         overrun,
    input  logic         ovr_clr
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t       state;
    logic [N-1:0] req_q;
    logic [N-1:0] rise;
    logic [N-1:0] cap;
    logic [N-1:0] clr;
    logic [N-1:0] code_oh;
    logic [N-1:0] rem;
    logic         accept;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [W-1:0] prio(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [W-1:0] c);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = (c == W'(i));
        end
        return r;
    endfunction

    always_comb begin
        accept  = code_valid && code_ready;
        rise    = req & ~req_q;
        cap     = en ? rise : '0;
        code_oh = onehot(code_o);
        clr     = accept ? code_oh : '0;
        // Same-cycle captures are excluded; they are picked up later via IDLE.
        rem     = pending & ~code_oh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            pending    <= '0;
            code_o     <= '0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | cap;

            if (|(cap & pending & ~clr)) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        code_o     <= prio(pending);
                        code_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        if (|rem) begin
                            code_o <= prio(rem);
                        end else begin
                            code_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    code_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pri_encoder_hs.md
Name: pri_encoder_hs

Overview:
- Sequential counterpart of the team's 2-to-4 decoder: a 4-to-2 priority encoder with request capture.
- Captures rising edges on N request lines into a sticky pending register.
- Presents the highest-index pending request as a binary code over a valid/ready handshake, then clears that bit when the consumer accepts it.
- Sits between asynchronous-ish event sources (buttons, status strobes) and a consumer that feeds the code back into a decoder.

Parameters:
N, 4, number of request lines
W, 2, code width; must satisfy 2^W >= N (W = clog2(N))

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
en  input  1  capture enable; 0 ignores new request edges
req  input  N  request lines, rising-edge sensitive
code_o  output  W  index of presented request
code_valid  output  1  code_o is valid
code_ready  input  1  consumer accepts code_o when high with code_valid
pending  output  N  registered pending-request vector
overrun  output  1  sticky: a request edge arrived while its bit was already pending
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - req_q=0, pending=0, code_o=0, code_valid=0, overrun=0, FSM=IDLE.
  - No capture occurs during reset.
  - Reset mid-handshake drops code_valid on that edge; the in-flight code is lost.
- Edge detect:
  - req_q<=req every cycle, including when en=0.
  - rise=req & ~req_q.
  - A line already high at reset release produces a rise on the first post-reset edge.
- Capture:
  - cap=en ? rise : 0.
  - clr=onehot(code_o) when code_valid&code_ready, else 0.
  - pending<=(pending & ~clr) | cap.
  - If cap and clr hit the same bit in the same cycle, cap wins: the bit stays set and there is no overrun.
- Overrun:
  - Set when cap[i] & pending[i] & ~clr[i] for any i.
  - Cleared by ovr_clr.
  - If set and clear occur in the same cycle, set wins.
  - The duplicate request is merged; only one code is delivered.
- Priority: highest set index wins. Evaluation uses the registered pending value only, never same-cycle cap.
- FSM IDLE:
  - code_valid=0.
  - If pending!=0: code_o<=prio(pending), code_valid<=1, go PRESENT.
- FSM PRESENT:
  - code_valid=1.
  - code_o is held stable while code_ready=0, even if a higher-priority request arrives. There is no preemption.
  - On accept (code_valid&code_ready), let rem=pending & ~onehot(code_o):
    - If rem!=0: code_o<=prio(rem) and stay PRESENT, giving back-to-back delivery with no bubble.
    - Otherwise code_valid<=0 and go IDLE. Requests captured in the accept cycle appear one cycle later via IDLE.
- Latency: req rises before edge E0 → pending bit set after E0 → code_valid=1 after E1, i.e. 2 cycles from the sampled edge.
- en=0:
  - Pending bits already captured are still served.
  - Edges occurring while en=0 are permanently dropped; they are not remembered when en returns to 1.
- Unused codes (N<2^W) never appear on code_o.

Test Plan:
1. Reset with req=4'b1111 held, rst_n=0 for 2 cycles, then released, code_ready=1 → during reset code_valid=0, pending=0, overrun=0. After release: pending=1111 after the first edge, then codes 3,2,1,0 on 4 consecutive cycles, then code_valid=0 and pending=0000.
2. Single pulse: 1-cycle pulse on req[1], code_ready=1 → code_valid high exactly 1 cycle, 2 edges after the sampled rise, with code_o=2'b01; pending returns to 0000.
3. Hold and priority, with code_ready=0:
   - Pulse req[0] and req[2] → code_o=2, held.
   - Then pulse req[3] → code_o stays 2, pending=1101.
   - Assert code_ready=1 → codes 2,3,0 back-to-back, then code_valid=0.
4. Overrun and clear-vs-rerise:
   - With code_ready=0, pulse req[0] twice → overrun=1, pending=0001, a single code 0 is delivered.
   - Pulse ovr_clr → overrun=0.
   - Accept code 1 in the same cycle as a new req[1] rise → pending[1] stays 1, code 1 is presented again, overrun stays 0.
5. Enable gating:
   - en=0, pulse req=1111 → pending stays 0000, code_valid stays 0.
   - Raise en=1 while req is held high → still no capture, because no new edge occurs.
6. Reset mid-operation: code_valid=1 with code_o=3 and pending=1010, then rst_n=0 for 1 cycle → next edge gives code_valid=0, pending=0, and no code 1 is delivered afterwards.
